// File: rtl/argmax_scan_classifier_if.sv
// Score-in / class-out bundle for argmax_scan_classifier.
// ARGMAX_MARGIN_EN adds the winner-to-runner-up margin signal.
interface argmax_scan_classifier_if #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 29
);
    logic [NUM_CLASSES*SCORE_W-1:0] layer_out;
    logic                           valid;
    logic                           in_ready;
    logic [31:0]                    predict;
    logic                           ready;
    logic                           overrun;
`ifdef ARGMAX_MARGIN_EN
    logic [SCORE_W:0]               margin;
`endif

    modport master (
        output layer_out, valid,
        input  in_ready, predict, ready,
`ifdef ARGMAX_MARGIN_EN
               margin,
`endif
               overrun
    );

    modport slave (
        input  layer_out, valid,
        output in_ready, predict, ready,
`ifdef ARGMAX_MARGIN_EN
               margin,
`endif
               overrun
    );
endinterface

// File: rtl/argmax_scan_classifier.sv
// Argmax output stage: captures NUM_CLASSES scores and scans them LANES per cycle.
// Optional feature macro ARGMAX_MARGIN_EN: tracks runner-up and reports best - runner_up.
module argmax_scan_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 29,
    parameter int LANES       = 1,
    parameter int SIGNED      = 0
) (
    input logic                     clk,
    input logic                     rst,
    argmax_scan_classifier_if.slave bus
);
    localparam int BEATS  = (NUM_CLASSES + LANES - 1) / LANES;
    localparam int PADDED = BEATS * LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    function automatic logic gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    logic [0:0]                state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [PADDED*SCORE_W-1:0] scores_q, scores_d;
    logic [SCORE_W-1:0]        best_q, best_d;
    logic [31:0]               best_idx_q, best_idx_d;
    logic [31:0]               predict_q, predict_d;
    logic                      ready_q, ready_d;
    logic                      overrun_q, overrun_d;
`ifdef ARGMAX_MARGIN_EN
    localparam logic [SCORE_W-1:0] SCORE_MIN =
        (SIGNED != 0) ? {1'b1, {(SCORE_W-1){1'b0}}} : '0;

    function automatic logic [SCORE_W:0] ext(input logic [SCORE_W-1:0] a);
        if (SIGNED != 0) return {a[SCORE_W-1], a};
        return {1'b0, a};
    endfunction

    logic [SCORE_W-1:0]        runner_q, runner_d;
    logic [SCORE_W:0]          margin_q, margin_d;
`endif

    logic [SCORE_W-1:0] cand;
    int                 idx;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        scores_d   = scores_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        predict_d  = predict_q;
        ready_d    = 1'b0;
        overrun_d  = overrun_q;
        cand       = '0;
        idx        = 0;
`ifdef ARGMAX_MARGIN_EN
        runner_d   = runner_q;
        margin_d   = margin_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    scores_d = '0;
                    scores_d[NUM_CLASSES*SCORE_W-1:0] = bus.layer_out;
                    best_d     = bus.layer_out[SCORE_W-1:0];
                    best_idx_d = '0;
                    beat_d     = '0;
                    state_d    = SCAN;
`ifdef ARGMAX_MARGIN_EN
                    runner_d   = SCORE_MIN;
`endif
                end
            end
            default: begin
                if (bus.valid) overrun_d = 1'b1;
                // Index 0 already seeds best, so it is skipped; padding lanes are masked.
                for (int l = 0; l < LANES; l++) begin
                    idx  = int'(beat_q) * LANES + l;
                    cand = scores_q[idx*SCORE_W +: SCORE_W];
                    if (idx != 0 && idx < NUM_CLASSES) begin
                        if (gt(cand, best_d)) begin
`ifdef ARGMAX_MARGIN_EN
                            runner_d = best_d;
`endif
                            best_d     = cand;
                            best_idx_d = 32'(idx);
                        end
`ifdef ARGMAX_MARGIN_EN
                        else if (gt(cand, runner_d)) begin
                            runner_d = cand;
                        end
`endif
                    end
                end
                if (beat_q == LAST_BEAT) begin
                    predict_d = best_idx_d;
                    ready_d   = 1'b1;
                    state_d   = IDLE;
`ifdef ARGMAX_MARGIN_EN
                    margin_d  = ext(best_d) - ext(runner_d);
`endif
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            scores_q   <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            predict_q  <= '0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            runner_q   <= '0;
            margin_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            scores_q   <= scores_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            predict_q  <= predict_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
`ifdef ARGMAX_MARGIN_EN
            runner_q   <= runner_d;
            margin_q   <= margin_d;
`endif
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.predict  = predict_q;
    assign bus.ready    = ready_q;
    assign bus.overrun  = overrun_q;
`ifdef ARGMAX_MARGIN_EN
    assign bus.margin   = margin_q;
`endif
endmodule
